fetch_unit: RTL

Parametrised instruction-fetch stage for the RISC-V multicycle core. It replaces the free-running "PC+4 every cycle" arrangement with an explicit fetch FSM. The FSM uses a request/valid handshake to instruction memory, a valid/ready handshake to decode, and branch/jump redirect with flush of an in-flight fetch. It sits between the PC/instruction-memory path and the decode/control FSM.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_pc_reg.sv | 16 +
 rtl/fetch_unit.sv | 68 ++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// riscv_fetch_pkg: shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FLUSH = 3'd4,
    S_ERR   = 3'd5
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decode and redirect signals of the fetch stage.
interface fetch_unit_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
);
  logic                                imem_req;
  logic [ADDR_W-1:0]                   imem_addr;
  logic [riscv_fetch_pkg::INSTR_W-1:0] imem_rdata;
  logic                                imem_valid;
  logic [riscv_fetch_pkg::INSTR_W-1:0] ir;
  logic                                ir_valid;
  logic                                ir_ready;
  logic [XLEN-1:0]                     pc;
  logic                                redirect;
  logic [XLEN-1:0]                     redirect_pc;
  modport master (
    output imem_req, imem_addr, ir, ir_valid, pc,
    input  imem_rdata, imem_valid, ir_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, ir, ir_valid, pc,
    output imem_rdata, imem_valid, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// fetch_pc_reg: program counter with load enable choosing pc+4 or a redirect target.
module fetch_pc_reg import riscv_fetch_pkg::*; #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            sel_target,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clock)
    if (reset) pc <= RESET_PC;
    else if (load) pc <= sel_target ? target : pc + XLEN'(PC_STEP);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: request/wait/hold fetch FSM with redirect, flush of in-flight reads and sticky misalignment.
module fetch_unit import riscv_fetch_pkg::*; #(
  parameter int              XLEN     = 64,
  parameter int              ADDR_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  fetch_unit_if.master    bus,
  output logic            misaligned,
  output logic [XLEN-1:0] fetch_count,
  output logic [2:0]      estado
);
  fetch_state_t         state, state_nxt;
  logic                 take, bad, accept, capture;
  logic [INSTR_W-1:0]   ir_q;
  logic                 ir_valid_q;
  logic [XLEN-1:0]      pc_q;

  fetch_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clock      (clock),
    .reset      (reset),
    .load       (take || accept),
    .sel_target (take),
    .target     (bus.redirect_pc),
    .pc         (pc_q)
  );

  // A redirect from REQ/WAIT/FLUSH leaves a read in flight unless its response lands this very cycle.
  always_comb begin
    take      = bus.redirect && state != S_ERR;
    bad       = take && bus.redirect_pc[1:0] != 2'b00;
    accept    = state == S_HOLD && bus.ir_ready && !take;
    capture   = state == S_WAIT && bus.imem_valid && !take;
    state_nxt = state;
    if (bad) state_nxt = S_ERR;
    else if (take)
      state_nxt = (state == S_REQ || ((state == S_WAIT || state == S_FLUSH) && !bus.imem_valid)) ? S_FLUSH : S_REQ;
    else
      state_nxt = state == S_RESET ? S_REQ :
                  state == S_REQ   ? S_WAIT :
                  state == S_WAIT  ? (bus.imem_valid ? S_HOLD : S_WAIT) :
                  state == S_HOLD  ? (bus.ir_ready ? S_REQ : S_HOLD) :
                  state == S_FLUSH ? (bus.imem_valid ? S_REQ : S_FLUSH) : S_ERR;
  end

  always_ff @(posedge clock)
    if (reset) begin
      state       <= S_RESET;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state      <= state_nxt;
      if (capture) ir_q <= bus.imem_rdata;
      ir_valid_q <= capture || (ir_valid_q && !accept && !take);
      misaligned <= misaligned || bad;
      if (accept) fetch_count <= fetch_count + XLEN'(1);
    end

  assign bus.imem_req  = state == S_REQ;
  assign bus.imem_addr = pc_q[ADDR_W-1:0];
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.pc        = pc_q;
  assign estado        = state;
endmodule
